writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Write side of the register-file write port, driving reg_file_wr_en, reg_file_wr_addr and reg_file_wr_data into decode.
//  Merges two result sources onto the single write port:
//   - in-order pipeline results from the memory stage (ALU or load data).
//   - out-of-band results from the multi-cycle M-extension unit (MUL/DIV), held in a small completion FIFO.
//  Performs load-data alignment and extension. Registers the write port.
// PARAMETERS
//  MD_DEPTH   2   completion FIFO entries for M-unit results (power of 2, >=2)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-low reset
//  wb_valid         in   1   memory-stage instruction valid this cycle
//  wb_reg_file      in   1   instruction writes rd
//  wb_load          in   1   1: write load data; 0: write alu_result
//  mem_load_type    in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  wb_rd            in   5   destination register
//  alu_result       in   32  ALU result / load address (bits [1:0] = byte offset)
//  mem_rdata        in   32  raw aligned data word from data memory
//  md_valid         in   1   M-unit result offered
//  md_ready         out  1   FIFO can accept (combinational: FIFO not full)
//  md_rd            in   5   M-unit destination register
//  md_result        in   32  M-unit result
//  reg_file_wr_en   out  1   register-file write enable (registered)
//  reg_file_wr_addr out  5   register-file write address (registered)
//  reg_file_wr_data out  32  register-file write data (registered)
//  md_pending       out  1   FIFO non-empty (for hazard/stall logic)
// BEHAVIOUR
//  Reset (rst=0, async)
//   - reg_file_wr_en=0, wr_addr=0, wr_data=0.
//   - FIFO emptied: md_pending=0, md_ready=1.
//   - Any in-flight or buffered write is discarded.
//  Pipeline write request: P = wb_valid & wb_reg_file & (wb_rd!=0).
//  Load data (wb_load=1), off = alu_result[1:0]:
//   - LB/LBU: byte mem_rdata[8*off+:8], sign- or zero-extended.
//   - LH/LHU: half mem_rdata[16*off[1]+:16], sign- or zero-extended; off[0] is ignored.
//   - LW: mem_rdata unchanged.
//   - Other codes: treated as LW.
//  Arbitration, evaluated each cycle:
//   - If P: the pipeline wins and the M-unit head waits.
//   - Else if the FIFO is non-empty: pop the head and write it.
//   - Else: no write.
//  Latency: write port updates on the edge after the request.
//   - reg_file_wr_en is high for exactly one cycle per write.
//   - Address and data hold their last values when wr_en=0.
//  FIFO handshake:
//   - Push on md_valid & md_ready.
//   - md_rd==0 is accepted but discarded: not stored, never written.
//   - Simultaneous push and pop: legal when full. md_ready stays low that cycle because it reflects current occupancy only.
//   - Push into an empty FIFO with no P: the entry is written on the next cycle's arbitration. No same-cycle bypass.
//  WAW supersede:
//   - When P fires, every valid FIFO entry whose rd==wb_rd is invalidated (the younger write wins).
//   - Invalidated entries are skipped on pop, so an empty slot never produces a write.
//   - A push in the same cycle with md_rd==wb_rd is NOT invalidated.
//  Pointer wrap: read/write pointers wrap modulo MD_DEPTH. Full/empty are distinguished by an extra pointer bit.
//  md_pending = any valid entry present.
// TESTING
//  1. LB, off=3, mem_rdata=0x80FF_1234, rd=5 -> next cycle wr_en=1, addr=5, data=0xFFFF_FF80. Same with LHU, off=2 -> data=0x0000_80FF.
//  2. ALU write to rd=0 (wb_valid=1, wb_reg_file=1) -> wr_en stays 0.
//  3. md_valid rd=7 result=0x1234 while P high for 3 cycles -> held (md_pending=1). Written 1 cycle after P drops.
//  4. Push MD_DEPTH entries under continuous P -> md_ready=0, further offers refused. Release P -> entries written in push order, one per cycle, then md_ready=1.
//  5. FIFO holds rd=9 value 0xAAAA, then P writes rd=9 value 0xBBBB -> only 0xBBBB is written and md_pending=0 afterwards.
//  6. Assert rst low with two FIFO entries and a pending write -> outputs 0 immediately. After release, no write occurs.

Source files
------------

// File: rtl/writeback_unit.sv
// Register-file write port: merges in-order pipeline results with buffered M-unit
// results, aligns/extends load data and registers the write.
module writeback_unit #(
  parameter int MD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_reg_file,
  input  logic        wb_load,
  input  logic [2:0]  mem_load_type,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_rdata,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_result,
  output logic        reg_file_wr_en,
  output logic [4:0]  reg_file_wr_addr,
  output logic [31:0] reg_file_wr_data,
  output logic        md_pending
);

  localparam int PW = $clog2(MD_DEPTH);

  typedef logic [PW:0] ptr_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  ptr_t                wr_ptr;
  ptr_t                rd_ptr;
  ptr_t                count;
  logic [4:0]          fifo_rd   [MD_DEPTH];
  logic [31:0]         fifo_data [MD_DEPTH];
  logic [MD_DEPTH-1:0] fifo_vld;

  logic          p_req;
  logic          push;
  logic          pop_any;
  logic          pop_wr;
  logic          found;
  ptr_t          sel_off;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] scan_idx;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_data;

  assign p_req      = wb_valid & wb_reg_file & (wb_rd != 5'd0);
  assign count      = wr_ptr - rd_ptr;
  assign md_ready   = (count != ptr_t'(MD_DEPTH));
  assign md_pending = |fifo_vld;
  // A zero destination is handshaken but never stored.
  assign push       = md_valid & md_ready & (md_rd != 5'd0);
  assign pop_any    = !p_req && (count != '0);
  assign pop_wr     = pop_any && found;

  // Oldest still-valid entry; superseded entries ahead of it are skipped by the pop.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    sel_off  = '0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < MD_DEPTH; i++) begin
      scan_idx = rd_ptr[PW-1:0] + PW'(i);
      if (!found && fifo_vld[scan_idx]) begin
        found   = 1'b1;
        sel_off = ptr_t'(i);
        sel_idx = scan_idx;
      end
    end
  end

  always_comb begin
    ld_byte = mem_rdata[{alu_result[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{alu_result[1], 4'b0000} +: 16];
    case (mem_load_type)
      LT_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:  load_data = {24'd0, ld_byte};
      LT_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      LT_LHU:  load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_vld <= '0;
    end else begin
      if (p_req) begin
        for (int i = 0; i < MD_DEPTH; i++) begin
          if (fifo_vld[i] && fifo_rd[i] == wb_rd) fifo_vld[i] <= 1'b0;
        end
      end
      if (pop_any) begin
        if (pop_wr) fifo_vld[sel_idx] <= 1'b0;
        rd_ptr <= found ? rd_ptr + sel_off + ptr_t'(1) : wr_ptr;
      end
      // Later assignment wins, so a same-cycle push is never superseded.
      if (push) begin
        fifo_vld[wr_ptr[PW-1:0]] <= 1'b1;
        wr_ptr                   <= wr_ptr + ptr_t'(1);
      end
    end
  end

  // NOTE: payload storage has no reset; only the valid bits and pointers need one.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[PW-1:0]]   <= md_rd;
      fifo_data[wr_ptr[PW-1:0]] <= md_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_file_wr_en   <= 1'b0;
      reg_file_wr_addr <= '0;
      reg_file_wr_data <= '0;
    end else begin
      reg_file_wr_en <= p_req | pop_wr;
      if (p_req) begin
        reg_file_wr_addr <= wb_rd;
        reg_file_wr_data <= wb_load ? load_data : alu_result;
      end else if (pop_wr) begin
        reg_file_wr_addr <= fifo_rd[sel_idx];
        reg_file_wr_data <= fifo_data[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_writeback_unit;

  localparam int MD_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_reg_file = 1'b0;
  logic        wb_load = 1'b0;
  logic [2:0]  mem_load_type = 3'd0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = 5'd0;
  logic [31:0] md_result = 32'd0;
  logic        reg_file_wr_en;
  logic [4:0]  reg_file_wr_addr;
  logic [31:0] reg_file_wr_data;
  logic        md_pending;

  writeback_unit #(.MD_DEPTH(MD_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg_file(wb_reg_file), .wb_load(wb_load),
    .mem_load_type(mem_load_type), .wb_rd(wb_rd), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .md_valid(md_valid), .md_ready(md_ready),
    .md_rd(md_rd), .md_result(md_result), .reg_file_wr_en(reg_file_wr_en),
    .reg_file_wr_addr(reg_file_wr_addr), .reg_file_wr_data(reg_file_wr_data),
    .md_pending(md_pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of buffered M results, in push order, each with a live flag.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        live;
  } md_entry_t;

  md_entry_t   q[$];
  logic        m_en   = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;

  function automatic logic [31:0] load_model(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (8 * off);
    h = w >> (16 * off[1]);
    case (t)
      3'b000:  return 32'($signed(b[7:0]));
      3'b100:  return 32'(b[7:0]);
      3'b001:  return 32'($signed(h[15:0]));
      3'b101:  return 32'(h[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic logic any_live();
    foreach (q[i]) if (q[i].live) return 1'b1;
    return 1'b0;
  endfunction

  // Compare on the falling edge, then advance the model with the inputs of this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      check("rst_wr_en", {31'd0, reg_file_wr_en}, 32'd0);
      check("rst_md_pending", {31'd0, md_pending}, 32'd0);
    end else begin
      logic p;
      logic ready;
      check("wr_en", {31'd0, reg_file_wr_en}, {31'd0, m_en});
      check("wr_addr", {27'd0, reg_file_wr_addr}, {27'd0, m_addr});
      check("wr_data", reg_file_wr_data, m_data);
      ready = (q.size() < MD_DEPTH);
      check("md_ready", {31'd0, md_ready}, {31'd0, ready});
      check("md_pending", {31'd0, md_pending}, {31'd0, any_live()});

      p = wb_valid && wb_reg_file && (wb_rd != 5'd0);
      m_en = 1'b0;
      if (p) begin
        m_en   = 1'b1;
        m_addr = wb_rd;
        m_data = wb_load ? load_model(mem_load_type, alu_result[1:0], mem_rdata) : alu_result;
        foreach (q[i]) if (q[i].rd == wb_rd) q[i].live = 1'b0;
      end else begin
        while (q.size() > 0 && !q[0].live) void'(q.pop_front());
        if (q.size() > 0) begin
          md_entry_t e;
          e = q.pop_front();
          m_en = 1'b1; m_addr = e.rd; m_data = e.data;
        end
      end
      if (md_valid && ready && md_rd != 5'd0) q.push_back('{md_rd, md_result, 1'b1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg_file = 1'b0; wb_load = 1'b0; md_valid = 1'b0;
  endtask

  task automatic drive_p(input logic [4:0] rd, input logic [31:0] val);
    wb_valid = 1'b1; wb_reg_file = 1'b1; wb_load = 1'b0; wb_rd = rd; alu_result = val;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] val);
    md_valid = 1'b1; md_rd = rd; md_result = val;
  endtask

  task automatic expect_wr(input string name, input logic [4:0] rd, input logic [31:0] val);
    check({name, "_en"}, {31'd0, reg_file_wr_en}, 32'd1);
    check({name, "_addr"}, {27'd0, reg_file_wr_addr}, {27'd0, rd});
    check({name, "_data"}, reg_file_wr_data, val);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_wr_data", reg_file_wr_data, 32'd0);
    check("reset_md_ready", {31'd0, md_ready}, 32'd1);
    rst = 1'b1;
    tick();

    // Load alignment and extension.
    wb_valid = 1'b1; wb_reg_file = 1'b1; wb_load = 1'b1; wb_rd = 5'd5;
    mem_load_type = 3'b000; alu_result = 32'h0000_0103; mem_rdata = 32'h80FF_1234;
    tick();
    expect_wr("lb_off3", 5'd5, 32'hFFFF_FF80);
    mem_load_type = 3'b101; alu_result = 32'h0000_0102;
    tick();
    expect_wr("lhu_off2", 5'd5, 32'h0000_80FF);

    // Write to x0 is dropped.
    wb_load = 1'b0; wb_rd = 5'd0; alu_result = 32'h1111_1111;
    tick();
    check("x0_no_write", {31'd0, reg_file_wr_en}, 32'd0);

    // M result held behind three pipeline writes.
    drive_p(5'd3, 32'h33);
    offer(5'd7, 32'h1234);
    tick();
    md_valid = 1'b0;
    check("held_pending", {31'd0, md_pending}, 32'd1);
    tick();
    tick();
    check("held_still", {31'd0, md_pending}, 32'd1);
    idle();
    tick();
    expect_wr("held_release", 5'd7, 32'h1234);
    check("held_drained", {31'd0, md_pending}, 32'd0);

    // Fill to capacity under continuous pipeline writes, then drain in order.
    drive_p(5'd1, 32'h11);
    offer(5'd12, 32'hC0);
    tick();
    offer(5'd13, 32'hD0);
    tick();
    check("full_ready", {31'd0, md_ready}, 32'd0);
    offer(5'd14, 32'hE0);
    tick();
    check("full_refused", {31'd0, md_ready}, 32'd0);
    idle();
    tick();
    expect_wr("drain0", 5'd12, 32'hC0);
    tick();
    expect_wr("drain1", 5'd13, 32'hD0);
    check("drain_ready", {31'd0, md_ready}, 32'd1);
    tick();
    check("drain_quiet", {31'd0, reg_file_wr_en}, 32'd0);

    // Younger pipeline write supersedes a buffered one.
    drive_p(5'd4, 32'h44);
    offer(5'd9, 32'hAAAA);
    tick();
    md_valid = 1'b0;
    drive_p(5'd9, 32'hBBBB);
    tick();
    expect_wr("waw_pipe", 5'd9, 32'hBBBB);
    check("waw_pending", {31'd0, md_pending}, 32'd0);
    idle();
    tick();
    check("waw_no_stale", {31'd0, reg_file_wr_en}, 32'd0);

    // Asynchronous reset with buffered entries and a write in flight.
    drive_p(5'd2, 32'h22);
    offer(5'd10, 32'hA0);
    tick();
    offer(5'd11, 32'hB0);
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_wr_en", {31'd0, reg_file_wr_en}, 32'd0);
    check("arst_wr_addr", {27'd0, reg_file_wr_addr}, 32'd0);
    check("arst_wr_data", reg_file_wr_data, 32'd0);
    check("arst_pending", {31'd0, md_pending}, 32'd0);
    check("arst_ready", {31'd0, md_ready}, 32'd1);
    idle();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("arst_after0", {31'd0, reg_file_wr_en}, 32'd0);
    tick();
    check("arst_after1", {31'd0, reg_file_wr_en}, 32'd0);

    // Randomized traffic with bursty pipeline pressure and a small register range.
    for (int blk = 0; blk < 40; blk++) begin
      int p_pct;
      p_pct = $urandom_range(10, 95);
      for (int c = 0; c < 75; c++) begin
        wb_valid      = ($urandom_range(99) < p_pct);
        wb_reg_file   = ($urandom_range(9) != 0);
        wb_load       = $urandom_range(1);
        mem_load_type = 3'($urandom_range(7));
        wb_rd         = 5'($urandom_range(7));
        alu_result    = $urandom;
        mem_rdata     = $urandom;
        md_valid      = ($urandom_range(99) < 60);
        md_rd         = 5'($urandom_range(7));
        md_result     = $urandom;
        tick();
      end
    end
    idle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
